// File: rtl/ahb_ws_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_ws_sram_slave.
// Carries the address/control, write data and the slave response signals.
// master modport drives requests; slave modport drives HREADYOUT/HRESP/HRDATA.
interface ahb_ws_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    output HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    input  HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_ws_sram_slave.sv
// AHB-Lite SRAM slave, 2^MEM_AW x 32-bit words, fixed wait states, two-cycle ERROR.
// Latency: OKAY data phase completes WAIT_STATES+1 cycles after the address edge.
// Backpressure: HREADYOUT low during wait/ERR1 cycles; new address accepted on any ready edge.
// Ports: HCLK, HRESETn (async active-low), bus (slave modport: AHB address/control,
//        HREADY, HWDATA in; HREADYOUT, HRESP, HRDATA out). HBURST/HPROT/HMASTLOCK unused.
module ahb_ws_sram_slave #(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 1
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_ws_sram_slave_if.slave bus
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d;     // an OKAY data phase is in flight
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [MEM_AW+1:0] addr_q, addr_d;

  logic [31:0] mem [2**MEM_AW];

  logic        ready;
  logic        accept;
  logic        addr_err;
  logic        complete;
  logic [3:0]  be;

  // Upper address bits alias, and the sideband attributes carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0],
                         bus.HADDR[31:MEM_AW+2]};

  always_comb begin
    ready = 1'b1;
    case (state_q)
      ST_WAIT: ready = (cnt_q == 4'd0);
      ST_ERR1: ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  // Only sample a new request on an edge where our own data phase can end.
  assign accept   = ready & bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign complete = vld_q & ready;

  always_comb begin
    addr_err = 1'b0;
    case (bus.HSIZE)
      3'd0:    addr_err = 1'b0;
      3'd1:    addr_err = bus.HADDR[0];
      3'd2:    addr_err = |bus.HADDR[1:0];
      default: addr_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;

    case (state_q)
      ST_WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      ST_ERR1: state_d = ST_ERR2;
      default: ;
    endcase

    // Any ready cycle closes the current data phase; the next one starts only on accept.
    if (ready) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
      if (accept) begin
        write_d = bus.HWRITE;
        size_d  = bus.HSIZE;
        addr_d  = bus.HADDR[MEM_AW+1:0];
        if (addr_err) begin
          state_d = ST_ERR1;
        end else begin
          vld_d = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_CNT;
          end
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      vld_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    be = 4'b1111;
    case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory is deliberately not reset; the write lands on the completion edge only.
  always_ff @(posedge HCLK) begin
    if (complete && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[MEM_AW+1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Asynchronous read so a read right behind a write sees the just-written word.
  assign bus.HRDATA    = (complete && !write_q) ? mem[addr_q[MEM_AW+1:2]] : 32'h0;
  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

endmodule

// File: tb/tb_ahb_ws_sram_slave.sv
module tb_ahb_ws_sram_slave;
  localparam int ND = 3;

  logic clk;
  logic rst_n;

  logic        hsel_s   [ND];
  logic [31:0] haddr_s  [ND];
  logic [1:0]  htrans_s [ND];
  logic        hwrite_s [ND];
  logic [2:0]  hsize_s  [ND];
  logic [31:0] hwdata_s [ND];
  logic        blk_s    [ND];
  logic [2:0]  hburst_s;
  logic [3:0]  hprot_s;
  logic        hlock_s;
  logic        rdy_w    [ND];
  logic        resp_w   [ND];
  logic [31:0] rdata_w  [ND];

  int n_chk;
  int n_fail;

  logic [31:0] mdl [ND][256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    ahb_ws_sram_slave_if bus();
    assign bus.HSEL      = hsel_s[g];
    assign bus.HADDR     = haddr_s[g];
    assign bus.HTRANS    = htrans_s[g];
    assign bus.HWRITE    = hwrite_s[g];
    assign bus.HSIZE     = hsize_s[g];
    assign bus.HBURST    = hburst_s;
    assign bus.HPROT     = hprot_s;
    assign bus.HMASTLOCK = hlock_s;
    assign bus.HWDATA    = hwdata_s[g];
    assign bus.HREADY    = bus.HREADYOUT & ~blk_s[g];
    assign rdy_w[g]      = bus.HREADYOUT;
    assign resp_w[g]     = bus.HRESP;
    assign rdata_w[g]    = bus.HRDATA;
    ahb_ws_sram_slave #(.MEM_AW(8), .WAIT_STATES(WS)) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .bus(bus)
    );
  end

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // Legal iff size fits a word and the address is a multiple of the access size.
  function automatic bit mdl_err(logic [31:0] a, logic [2:0] sz);
    int nb;
    if (sz > 3'd2) return 1'b1;
    nb = 1 << sz;
    return (int'(a[1:0]) % nb) != 0;
  endfunction

  function automatic logic [31:0] mdl_merge(logic [31:0] old, logic [31:0] wd,
                                            logic [31:0] a, logic [2:0] sz);
    logic [31:0] r;
    int first;
    int nb;
    r = old;
    first = int'(a[1:0]);
    nb = 1 << sz;
    for (int b = first; b < first + nb; b++) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic void mdl_apply(int k, bit wr, logic [31:0] a, logic [2:0] sz,
                                    logic [31:0] wd);
    if (wr && !mdl_err(a, sz)) mdl[k][a[9:2]] = mdl_merge(mdl[k][a[9:2]], wd, a, sz);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < ND; k++) begin
      hsel_s[k] = 1'b0; haddr_s[k] = 32'h0; htrans_s[k] = 2'b00;
      hwrite_s[k] = 1'b0; hsize_s[k] = 3'd0; hwdata_s[k] = 32'h0; blk_s[k] = 1'b0;
    end
  endtask

  // Single non-pipelined transfer; starts and ends just after a rising edge.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output int low, output bit resp_end,
                      output logic [31:0] rd, output bit stray, output bit resp_low);
    bit done;
    hsel_s[k] = 1'b1; htrans_s[k] = 2'b10; haddr_s[k] = a;
    hwrite_s[k] = wr; hsize_s[k] = sz;
    @(posedge clk); #1;
    hsel_s[k] = 1'b0; htrans_s[k] = 2'b00; hwdata_s[k] = wd;
    low = 0; done = 1'b0; resp_end = 1'b0; rd = 32'h0; stray = 1'b0; resp_low = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (rdy_w[k]) begin
        done = 1'b1; resp_end = resp_w[k]; rd = rdata_w[k];
      end else begin
        low++;
        if (rdata_w[k] !== 32'h0) stray = 1'b1;
        if (resp_w[k]) resp_low = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) low = -1;
  endtask

  task automatic run_chk(input string tag, input int k, input bit wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input int e_low,
                         input bit e_resp, input logic [31:0] e_rd);
    int low;
    bit resp_end, stray, resp_low;
    logic [31:0] rd;
    xfer(k, wr, a, sz, wd, low, resp_end, rd, stray, resp_low);
    chk({tag, ".lowcyc"}, 32'(low), 32'(e_low));
    chk({tag, ".resp"}, {31'h0, resp_end}, {31'h0, e_resp});
    chk({tag, ".rdata"}, rd, e_rd);
    chk({tag, ".stray"}, {31'h0, stray}, 32'h0);
    chk({tag, ".resplow"}, {31'h0, resp_low}, {31'h0, e_resp});
  endtask

  typedef struct {
    int          k;
    bit          wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          low;
    bit          resp;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int lowc;
    bit done;
    logic [31:0] r, a, wd;
    logic [2:0] sz;
    bit wr, er;

    n_chk = 0; n_fail = 0;
    hburst_s = 3'd0; hprot_s = 4'h3; hlock_s = 1'b0;
    idle_all();

    tbl[0]  = '{1, 1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF, 2, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b0, 32'h0000_0010, 3'd2, 32'h0,        2, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1, 1'b1, 32'h0000_0000, 3'd2, 32'h11223344, 2, 1'b0, 32'h0};
    tbl[3]  = '{1, 1'b1, 32'h0000_0003, 3'd1, 32'hFFFFFFFF, 1, 1'b1, 32'h0};
    tbl[4]  = '{1, 1'b0, 32'h0000_0000, 3'd2, 32'h0,        2, 1'b0, 32'h11223344};
    tbl[5]  = '{1, 1'b1, 32'h0000_0410, 3'd2, 32'hCAFEF00D, 2, 1'b0, 32'h0};
    tbl[6]  = '{1, 1'b0, 32'h0000_0010, 3'd2, 32'h0,        2, 1'b0, 32'hCAFEF00D};
    tbl[7]  = '{1, 1'b1, 32'h0000_0012, 3'd0, 32'h00550000, 2, 1'b0, 32'h0};
    tbl[8]  = '{1, 1'b0, 32'hFFFF_FC10, 3'd2, 32'h0,        2, 1'b0, 32'hCA55F00D};
    tbl[9]  = '{1, 1'b0, 32'h0000_0020, 3'd3, 32'h0,        1, 1'b1, 32'h0};
    tbl[10] = '{1, 1'b1, 32'h0000_0004, 3'd2, 32'h0,        2, 1'b0, 32'h0};
    tbl[11] = '{1, 1'b1, 32'h0000_0006, 3'd1, 32'hBEEF0000, 2, 1'b0, 32'h0};
    tbl[12] = '{1, 1'b0, 32'h0000_0004, 3'd2, 32'h0,        2, 1'b0, 32'hBEEF0000};
    tbl[13] = '{1, 1'b1, 32'h0000_0002, 3'd2, 32'h0,        1, 1'b1, 32'h0};
    tbl[14] = '{1, 1'b0, 32'h0000_0000, 3'd2, 32'h0,        2, 1'b0, 32'h11223344};
    tbl[15] = '{0, 1'b1, 32'h0000_0020, 3'd2, 32'h01020304, 0, 1'b0, 32'h0};
    tbl[16] = '{0, 1'b0, 32'h0000_0020, 3'd2, 32'h0,        0, 1'b0, 32'h01020304};
    tbl[17] = '{0, 1'b1, 32'h0000_0023, 3'd0, 32'hFF000000, 0, 1'b0, 32'h0};
    tbl[18] = '{0, 1'b0, 32'h0000_0020, 3'd2, 32'h0,        0, 1'b0, 32'hFF020304};
    tbl[19] = '{2, 1'b1, 32'h0000_0040, 3'd2, 32'h13579BDF, 3, 1'b0, 32'h0};
    tbl[20] = '{2, 1'b0, 32'h0000_0040, 3'd2, 32'h0,        3, 1'b0, 32'h13579BDF};
    tbl[21] = '{0, 1'b1, 32'h0000_0031, 3'd1, 32'h12345678, 1, 1'b1, 32'h0};

    // Reset: force a real falling edge, then check the idle response of every instance.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("rst%0d.ready", k), {31'h0, rdy_w[k]}, 32'h1);
      chk($sformatf("rst%0d.resp", k), {31'h0, resp_w[k]}, 32'h0);
      chk($sformatf("rst%0d.rdata", k), rdata_w[k], 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      run_chk($sformatf("vec%0d", i), tbl[i].k, tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd,
              tbl[i].low, tbl[i].resp, tbl[i].rd);
      mdl_apply(tbl[i].k, tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd);
    end

    // Zero-wait byte write to 0x21 pipelined straight into a word read of 0x20.
    hsel_s[0] = 1'b1; htrans_s[0] = 2'b10; haddr_s[0] = 32'h21;
    hwrite_s[0] = 1'b1; hsize_s[0] = 3'd0;
    @(posedge clk); #1;
    haddr_s[0] = 32'h20; hwrite_s[0] = 1'b0; hsize_s[0] = 3'd2; hwdata_s[0] = 32'h0000AA00;
    mdl_apply(0, 1'b1, 32'h21, 3'd0, 32'h0000AA00);
    @(negedge clk);
    chk("b2b.wr_ready", {31'h0, rdy_w[0]}, 32'h1);
    @(posedge clk); #1;
    hsel_s[0] = 1'b0; htrans_s[0] = 2'b00;
    @(negedge clk);
    chk("b2b.rd_ready", {31'h0, rdy_w[0]}, 32'h1);
    chk("b2b.rd_byte1", {24'h0, rdata_w[0][15:8]}, 32'hAA);
    chk("b2b.rd_word", rdata_w[0], mdl[0][8]);
    @(posedge clk); #1;

    // Misaligned halfword error, next transfer issued during ERR2.
    hsel_s[1] = 1'b1; htrans_s[1] = 2'b10; haddr_s[1] = 32'h03;
    hwrite_s[1] = 1'b1; hsize_s[1] = 3'd1;
    @(posedge clk); #1;
    hsel_s[1] = 1'b0; htrans_s[1] = 2'b00; hwdata_s[1] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("err.c1_ready", {31'h0, rdy_w[1]}, 32'h0);
    chk("err.c1_resp", {31'h0, resp_w[1]}, 32'h1);
    @(posedge clk); #1;
    hsel_s[1] = 1'b1; htrans_s[1] = 2'b10; haddr_s[1] = 32'h00;
    hwrite_s[1] = 1'b0; hsize_s[1] = 3'd2;
    @(negedge clk);
    chk("err.c2_ready", {31'h0, rdy_w[1]}, 32'h1);
    chk("err.c2_resp", {31'h0, resp_w[1]}, 32'h1);
    @(posedge clk); #1;
    hsel_s[1] = 1'b0; htrans_s[1] = 2'b00;
    lowc = 0; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (rdy_w[1]) begin
        done = 1'b1;
        chk("err.next_rdata", rdata_w[1], mdl[1][0]);
        chk("err.next_resp", {31'h0, resp_w[1]}, 32'h0);
      end else lowc++;
      @(posedge clk); #1;
    end
    chk("err.next_done", {31'h0, done}, 32'h1);
    chk("err.next_lowcyc", 32'(lowc), 32'd2);

    // NONSEQ held with HREADY low must not be taken.
    blk_s[0] = 1'b1;
    hsel_s[0] = 1'b1; htrans_s[0] = 2'b10; haddr_s[0] = 32'h20;
    hwrite_s[0] = 1'b1; hsize_s[0] = 3'd2; hwdata_s[0] = 32'hFFFFFFFF;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("hrdy0.ready%0d", n), {31'h0, rdy_w[0]}, 32'h1);
      @(posedge clk); #1;
    end
    hsel_s[0] = 1'b0; htrans_s[0] = 2'b00; blk_s[0] = 1'b0;
    @(negedge clk);
    chk("hrdy0.after_ready", {31'h0, rdy_w[0]}, 32'h1);
    chk("hrdy0.after_rdata", rdata_w[0], 32'h0);
    @(posedge clk); #1;
    run_chk("hrdy0.readback", 0, 1'b0, 32'h20, 3'd2, 32'h0, 0, 1'b0, mdl[0][8]);

    // Reset in the second wait cycle of a WAIT_STATES=3 write.
    hsel_s[2] = 1'b1; htrans_s[2] = 2'b10; haddr_s[2] = 32'h40;
    hwrite_s[2] = 1'b1; hsize_s[2] = 3'd2;
    @(posedge clk); #1;
    hsel_s[2] = 1'b0; htrans_s[2] = 2'b00; hwdata_s[2] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rstw.w1_ready", {31'h0, rdy_w[2]}, 32'h0);
    @(posedge clk); #1;
    chk("rstw.w2_ready", {31'h0, rdy_w[2]}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rstw.ready", {31'h0, rdy_w[2]}, 32'h1);
    chk("rstw.resp", {31'h0, resp_w[2]}, 32'h0);
    chk("rstw.rdata", rdata_w[2], 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.first_ready", {31'h0, rdy_w[2]}, 32'h1);
    chk("rstw.first_resp", {31'h0, resp_w[2]}, 32'h0);
    @(posedge clk); #1;
    run_chk("rstw.readback", 2, 1'b0, 32'h40, 3'd2, 32'h0, 3, 1'b0, mdl[2][16]);
    run_chk("rstw.keep1", 1, 1'b0, 32'h10, 3'd2, 32'h0, 2, 1'b0, mdl[1][4]);

    // Randomised traffic in words 64..127 against the reference model.
    for (int k = 0; k < ND; k++) begin
      for (int w = 64; w < 128; w++) begin
        wd = $urandom;
        run_chk($sformatf("init%0d_%0d", k, w), k, 1'b1, 32'(w * 4), 3'd2, wd,
                ws_of(k), 1'b0, 32'h0);
        mdl_apply(k, 1'b1, 32'(w * 4), 3'd2, wd);
      end
    end
    for (int k = 0; k < ND; k++) begin
      for (int t = 0; t < 120; t++) begin
        r = $urandom;
        a = {r[31:10], 2'b01, r[7:0]};
        sz = 3'($urandom_range(0, 3));
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        r = $urandom;
        hburst_s = r[2:0]; hprot_s = r[6:3]; hlock_s = r[7];
        er = mdl_err(a, sz);
        run_chk($sformatf("rnd%0d_%0d", k, t), k, wr, a, sz, wd,
                er ? 1 : ws_of(k), er,
                (er || wr) ? 32'h0 : mdl[k][a[9:2]]);
        mdl_apply(k, wr, a, sz, wd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ws_sram_slave.md
AHB_WS_SRAM_SLAVE -- requirements
Module: ahb_ws_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, word-address width; memory depth is 2^MEM_AW 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, wait cycles inserted per OKAY transfer; legal range 0..15.
REQ-003 SHALL have port HCLK, input, 1 bit, AHB clock.
REQ-004 SHALL have port HRESETn, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port HSEL, input, 1 bit, slave select from the matrix output stage.
REQ-006 SHALL have port HADDR, input, 32 bits, address.
REQ-007 SHALL have port HTRANS, input, 2 bits, transfer type.
REQ-008 SHALL have port HWRITE, input, 1 bit, direction (1 = write).
REQ-009 SHALL have port HSIZE, input, 3 bits, transfer size.
REQ-010 SHALL have ports HBURST (3 bits), HPROT (4 bits) and HMASTLOCK (1 bit) as inputs, and SHALL ignore all three functionally.
REQ-011 SHALL have port HREADY, input, 1 bit, muxed bus ready (HREADYMUX).
REQ-012 SHALL have port HWDATA, input, 32 bits, write data.
REQ-013 SHALL have port HREADYOUT, output, 1 bit, slave ready.
REQ-014 SHALL have port HRESP, output, 1 bit, response (0 = OKAY, 1 = ERROR).
REQ-015 SHALL have port HRDATA, output, 32 bits, read data.

Function
REQ-016 SHALL accept an address phase only on a rising HCLK edge where HSEL=1, HTRANS[1]=1 and HREADY=1; at that edge it SHALL register HADDR[MEM_AW+1:0], HWRITE and HSIZE.
REQ-017 SHALL treat IDLE/BUSY, HSEL=0, or HREADY=0 as no transfer, giving a zero-wait OKAY data phase (HREADYOUT=1, HRESP=0).
REQ-018 SHALL flag an error for a transfer with HSIZE>2, or a halfword with HADDR[0]=1, or a word with HADDR[1:0]!=0.
REQ-019 SHALL implement the FSM states IDLE, WAIT, ERR1 and ERR2.
REQ-020 FSM transitions from IDLE or the final WAIT cycle on an accepted transfer: error -> ERR1; WAIT_STATES>0 -> WAIT with the counter loaded to WAIT_STATES; WAIT_STATES=0 -> complete in the next cycle.
REQ-021 In WAIT, SHALL drive HREADYOUT=0 while the counter is nonzero, decrement the counter each cycle, and drive HREADYOUT=1 in the cycle the counter equals 0.
REQ-022 SHALL give an OKAY data phase a latency of WAIT_STATES+1 cycles from the address-phase edge.
REQ-023 In ERR1, SHALL drive HRESP=1 and HREADYOUT=0; in ERR2, HRESP=1 and HREADYOUT=1; ERR1 SHALL be followed by ERR2 unconditionally, with no wait states inserted.
REQ-024 SHALL accept a new address phase at the ERR2 edge or a completion edge (back-to-back pipelining).
REQ-025 A write SHALL update memory only at the completion edge (HREADYOUT=1), using HWDATA with byte lanes taken from the registered size and address: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes.
REQ-026 Errored transfers SHALL never modify memory.
REQ-027 A read SHALL present mem[addr[MEM_AW+1:2]] (full word) on HRDATA in its completion cycle; HRDATA SHALL be 0 in all other cycles.
REQ-028 A read immediately following a write to the same word SHALL return the new data, including when WAIT_STATES=0.
REQ-029 Address bits above MEM_AW+1 SHALL be ignored (aliasing/wrap); no error SHALL be raised for out-of-range addresses.
REQ-030 HREADY=0 while this slave is idle SHALL cause no state change.

Reset
REQ-031 On HRESETn=0 the block SHALL asynchronously enter IDLE with counter=0, HREADYOUT=1, HRESP=0, HRDATA=0 and the registered address-phase valid bit cleared.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset asserted mid-WAIT or mid-ERR SHALL abort the transfer with no memory write, and the first cycle after reset SHALL be an OKAY/ready cycle.

Verification
REQ-034 WAIT_STATES=2, word write 0xDEADBEEF to 0x10 -> HREADYOUT low for 2 cycles then high; a following word read of 0x10 returns 0xDEADBEEF after 2 low cycles.
REQ-035 WAIT_STATES=0, byte write 0xAA to 0x21 then immediate word read of 0x20 -> HRDATA[15:8]=0xAA and other bytes unchanged, zero wait.
REQ-036 Halfword access to 0x03 -> cycle 1 HRESP=1/HREADYOUT=0, cycle 2 HRESP=1/HREADYOUT=1, memory unchanged, next transfer accepted at the ERR2 edge.
REQ-037 HSEL=1 with HTRANS=NONSEQ and HREADY=0 -> no transfer accepted, memory unchanged, HREADYOUT stays 1.
REQ-038 WAIT_STATES=3, HRESETn pulsed low during the second wait cycle of a write -> HREADYOUT=1 and HRESP=0 immediately, target word keeps its old value.
REQ-039 Address 0x0000_0400+0x10 with MEM_AW=8 -> aliases to word 4, OKAY.
